// File: rtl/pipe_ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths, stall-vector
// indices and the per-cycle action priority.
package pipe_ex_mem_pkg;

   localparam int unsigned DefDataW  = 32;
   localparam int unsigned DefAddrW  = 5;
   localparam int unsigned DefNumCh  = 1;
   localparam int unsigned DefStallW = 6;
   localparam int unsigned DefCntW   = 2;

   localparam int unsigned STALL_PC  = 0;
   localparam int unsigned STALL_IF  = 1;
   localparam int unsigned STALL_ID  = 2;
   localparam int unsigned STALL_EX  = 3;
   localparam int unsigned STALL_MEM = 4;
   localparam int unsigned STALL_WB  = 5;

   typedef enum logic [2:0] {
      ActReset,
      ActFlush,
      ActBubble,
      ActAdvance,
      ActHold
   } action_e;

   // Priority: reset, flush, bubble, advance, hold.
   function automatic action_e pick_action(input logic rst_n, input logic flush,
                                           input logic stall_here, input logic stall_next);
      if (!rst_n) begin
         return ActReset;
      end else if (flush) begin
         return ActFlush;
      end else if (stall_here && !stall_next) begin
         return ActBubble;
      end else if (!stall_here) begin
         return ActAdvance;
      end
      return ActHold;
   endfunction

endpackage

// File: rtl/pipe_ch_reg.sv
// One register-file write channel (addr/en/data) of the EX/MEM pipeline register.
module pipe_ch_reg #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              en_o,
   output logic [DATA_W-1:0] data_o
);

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              en_d, en_q;
   logic [DATA_W-1:0] data_d, data_q;

   always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      data_d = data_q;
      if (clr_i) begin
         addr_d = '0;
         en_d   = 1'b0;
         data_d = '0;
      end else if (ld_i) begin
         addr_d = addr_i;
         en_d   = en_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         addr_q <= '0;
         en_q   <= 1'b0;
         data_q <= '0;
      end else begin
         addr_q <= addr_d;
         en_q   <= en_d;
         data_q <= data_d;
      end
   end

   assign addr_o = addr_q;
   assign en_o   = en_q;
   assign data_o = data_q;

endmodule

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register with flush, bubble/hold stall handling and multi-cycle feedback.
// Optional bubble/hold performance counters are built when PIPE_EX_MEM_PERF_EN is defined.
module pipe_ex_mem
   import pipe_ex_mem_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned NUM_CH  = DefNumCh,
   parameter int unsigned STALL_W = DefStallW,
   parameter int unsigned STAGE   = STALL_EX,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [STALL_W-1:0]       stall_en,
   input  logic                     flush,
   input  logic [NUM_CH*ADDR_W-1:0] out_addr,
   input  logic [NUM_CH-1:0]        out_en,
   input  logic [NUM_CH*DATA_W-1:0] out_data,
   input  logic                     hilo_wr_en,
   input  logic [DATA_W-1:0]        hilo_wr_hi,
   input  logic [DATA_W-1:0]        hilo_wr_lo,
   input  logic [2*DATA_W-1:0]      hilo_temp_in,
   input  logic [CNT_W-1:0]         cnt_in,
   output logic [NUM_CH*ADDR_W-1:0] pipe_out_addr,
   output logic [NUM_CH-1:0]        pipe_out_en,
   output logic [NUM_CH*DATA_W-1:0] pipe_out_data,
   output logic                     pipe_hilo_en,
   output logic [DATA_W-1:0]        pipe_hilo_hi,
   output logic [DATA_W-1:0]        pipe_hilo_lo,
   output logic                     pipe_valid,
   output logic [2*DATA_W-1:0]      hilo_temp_out,
   output logic [CNT_W-1:0]         cnt_out
`ifdef PIPE_EX_MEM_PERF_EN
   ,
   output logic [31:0]              perf_bubble_cnt,
   output logic [31:0]              perf_hold_cnt
`endif
);

   action_e act;
   logic    ch_clr, ch_ld;
   logic    unused_stall;

   // Only the own-stage and next-stage bits matter here.
   assign unused_stall = ^stall_en;

   always_comb begin
      act    = pick_action(reset, flush, stall_en[STAGE], stall_en[STAGE+1]);
      ch_clr = (act == ActFlush) || (act == ActBubble);
      ch_ld  = (act == ActAdvance);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pipe_ch_reg #(
         .ADDR_W(ADDR_W),
         .DATA_W(DATA_W)
      ) u_ch (
         .clk_i (clk),
         .rst_ni(reset),
         .clr_i (ch_clr),
         .ld_i  (ch_ld),
         .addr_i(out_addr[g*ADDR_W +: ADDR_W]),
         .en_i  (out_en[g]),
         .data_i(out_data[g*DATA_W +: DATA_W]),
         .addr_o(pipe_out_addr[g*ADDR_W +: ADDR_W]),
         .en_o  (pipe_out_en[g]),
         .data_o(pipe_out_data[g*DATA_W +: DATA_W])
      );
   end

   logic                hilo_en_d, hilo_en_q;
   logic [DATA_W-1:0]   hilo_hi_d, hilo_hi_q;
   logic [DATA_W-1:0]   hilo_lo_d, hilo_lo_q;
   logic                valid_d, valid_q;
   logic [2*DATA_W-1:0] temp_d, temp_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;

   always_comb begin
      hilo_en_d = hilo_en_q;
      hilo_hi_d = hilo_hi_q;
      hilo_lo_d = hilo_lo_q;
      valid_d   = valid_q;
      temp_d    = temp_q;
      cnt_d     = cnt_q;
      unique case (act)
         ActReset, ActFlush: begin
            hilo_en_d = 1'b0;
            hilo_hi_d = '0;
            hilo_lo_d = '0;
            valid_d   = 1'b0;
            temp_d    = '0;
            cnt_d     = '0;
         end
         // MEM gets a bubble while EX keeps iterating on its partial result.
         ActBubble: begin
            hilo_en_d = 1'b0;
            hilo_hi_d = '0;
            hilo_lo_d = '0;
            valid_d   = 1'b0;
            temp_d    = hilo_temp_in;
            cnt_d     = cnt_in;
         end
         ActAdvance: begin
            hilo_en_d = hilo_wr_en;
            hilo_hi_d = hilo_wr_hi;
            hilo_lo_d = hilo_wr_lo;
            valid_d   = 1'b1;
            temp_d    = '0;
            cnt_d     = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hilo_en_q <= 1'b0;
         hilo_hi_q <= '0;
         hilo_lo_q <= '0;
         valid_q   <= 1'b0;
         temp_q    <= '0;
         cnt_q     <= '0;
      end else begin
         hilo_en_q <= hilo_en_d;
         hilo_hi_q <= hilo_hi_d;
         hilo_lo_q <= hilo_lo_d;
         valid_q   <= valid_d;
         temp_q    <= temp_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pipe_hilo_en  = hilo_en_q;
   assign pipe_hilo_hi  = hilo_hi_q;
   assign pipe_hilo_lo  = hilo_lo_q;
   assign pipe_valid    = valid_q;
   assign hilo_temp_out = temp_q;
   assign cnt_out       = cnt_q;

`ifdef PIPE_EX_MEM_PERF_EN
   logic [31:0] bubble_cnt_q, hold_cnt_q;

   // Saturating; flush does not clear these.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bubble_cnt_q <= '0;
         hold_cnt_q   <= '0;
      end else begin
         if (act == ActBubble && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
         if (act == ActHold && hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + 32'd1;
      end
   end

   assign perf_bubble_cnt = bubble_cnt_q;
   assign perf_hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Self-checking bench for pipe_ex_mem (two channels): cycle model plus literal checks.
module tb_pipe_ex_mem;

   localparam int NCH = 2;

   logic          clk = 1'b0;
   logic          reset, flush;
   logic [5:0]    stall_en;
   logic [9:0]    out_addr;
   logic [1:0]    out_en;
   logic [63:0]   out_data;
   logic          hilo_wr_en;
   logic [31:0]   hilo_wr_hi, hilo_wr_lo;
   logic [63:0]   hilo_temp_in;
   logic [1:0]    cnt_in;
   logic [9:0]    pipe_out_addr;
   logic [1:0]    pipe_out_en;
   logic [63:0]   pipe_out_data;
   logic          pipe_hilo_en;
   logic [31:0]   pipe_hilo_hi, pipe_hilo_lo;
   logic          pipe_valid;
   logic [63:0]   hilo_temp_out;
   logic [1:0]    cnt_out;
`ifdef PIPE_EX_MEM_PERF_EN
   logic [31:0]   perf_bubble_cnt, perf_hold_cnt;
`endif

   int checks = 0;
   int errors = 0;

   pipe_ex_mem #(
      .NUM_CH(NCH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_en     (stall_en),
      .flush        (flush),
      .out_addr     (out_addr),
      .out_en       (out_en),
      .out_data     (out_data),
      .hilo_wr_en   (hilo_wr_en),
      .hilo_wr_hi   (hilo_wr_hi),
      .hilo_wr_lo   (hilo_wr_lo),
      .hilo_temp_in (hilo_temp_in),
      .cnt_in       (cnt_in),
      .pipe_out_addr(pipe_out_addr),
      .pipe_out_en  (pipe_out_en),
      .pipe_out_data(pipe_out_data),
      .pipe_hilo_en (pipe_hilo_en),
      .pipe_hilo_hi (pipe_hilo_hi),
      .pipe_hilo_lo (pipe_hilo_lo),
      .pipe_valid   (pipe_valid),
      .hilo_temp_out(hilo_temp_out),
      .cnt_out      (cnt_out)
`ifdef PIPE_EX_MEM_PERF_EN
      ,
      .perf_bubble_cnt(perf_bubble_cnt),
      .perf_hold_cnt  (perf_hold_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: the MEM-side view and the EX feedback, updated from the rules.
   logic [9:0]  m_addr;
   logic [1:0]  m_en;
   logic [63:0] m_data;
   logic        m_hen;
   logic [31:0] m_hi, m_lo;
   logic        m_valid;
   logic [63:0] m_temp;
   logic [1:0]  m_cnt;
   longint      m_bubbles, m_holds;
   bit          m_ok = 1'b0;

   task automatic m_kill_mem();
      m_addr = '0; m_en = '0; m_data = '0;
      m_hen = 1'b0; m_hi = '0; m_lo = '0; m_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      if (reset === 1'b0) begin
         m_kill_mem(); m_temp = '0; m_cnt = '0;
         m_bubbles = 0; m_holds = 0; m_ok = 1'b1;
      end else if (flush) begin
         m_kill_mem(); m_temp = '0; m_cnt = '0;
      end else if (!stall_en[3]) begin
         m_addr = out_addr; m_en = out_en; m_data = out_data;
         m_hen = hilo_wr_en; m_hi = hilo_wr_hi; m_lo = hilo_wr_lo;
         m_valid = 1'b1; m_temp = '0; m_cnt = '0;
      end else if (!stall_en[4]) begin
         m_kill_mem(); m_temp = hilo_temp_in; m_cnt = cnt_in;
         if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
      end else begin
         if (m_holds < 64'hFFFF_FFFF) m_holds++;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_addr", pipe_out_addr, m_addr);
         chk("m_en", pipe_out_en, m_en);
         chk("m_data", pipe_out_data, m_data);
         chk("m_hilo", {pipe_hilo_en, pipe_hilo_hi, pipe_hilo_lo}, {m_hen, m_hi, m_lo});
         chk("m_valid", pipe_valid, m_valid);
         chk("m_feedback", {hilo_temp_out, cnt_out}, {m_temp, m_cnt});
`ifdef PIPE_EX_MEM_PERF_EN
         chk("m_perf", {perf_bubble_cnt, perf_hold_cnt}, {m_bubbles[31:0], m_holds[31:0]});
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   logic [5:0] stall_tab[12] = '{6'b000000, 6'b001000, 6'b011000, 6'b111111,
                                 6'b000111, 6'b010000, 6'b001111, 6'b011111,
                                 6'b000000, 6'b101000, 6'b011111, 6'b000001};

   initial begin
      reset = 1'b0; flush = 1'b0; stall_en = '0;
      out_addr = '1; out_en = '1; out_data = '1;
      hilo_wr_en = 1'b1; hilo_wr_hi = '1; hilo_wr_lo = '1;
      hilo_temp_in = '1; cnt_in = '1;
      cyc(2);
      chk("rst_valid", pipe_valid, 1'b0);
      chk("rst_data", pipe_out_data, 64'h0);
      chk("rst_feedback", {hilo_temp_out, cnt_out}, 66'h0);

      reset = 1'b1;
      out_addr = {5'd7, 5'd3}; out_en = 2'b01; out_data = {32'hCAFE_F00D, 32'h1234_5678};
      hilo_wr_en = 1'b1; hilo_wr_hi = 32'h1111; hilo_wr_lo = 32'h2222;
      hilo_temp_in = 64'h99; cnt_in = 2'd3;
      cyc(1);
      chk("adv_addr", pipe_out_addr, {5'd7, 5'd3});
      chk("adv_en", pipe_out_en, 2'b01);
      chk("adv_data", pipe_out_data, {32'hCAFE_F00D, 32'h1234_5678});
      chk("adv_hi", pipe_hilo_hi, 32'h1111);
      chk("adv_valid", pipe_valid, 1'b1);

      stall_en = 6'b001111; cnt_in = 2'd1; hilo_temp_in = 64'hA5;
      cyc(1);
      chk("bub_valid", pipe_valid, 1'b0);
      chk("bub_data", pipe_out_data, 64'h0);
      chk("bub_cnt", cnt_out, 2'd1);
      chk("bub_temp", hilo_temp_out, 64'hA5);

      stall_en = 6'b000000; cnt_in = 2'd2; hilo_temp_in = 64'h77;
      cyc(1);
      chk("adv2_feedback", {hilo_temp_out, cnt_out}, 66'h0);

      out_data = {32'h0, 32'hDEAD_BEEF};
      cyc(1);
      stall_en = 6'b011111; out_data = 64'h0;
      cyc(3);
      chk("hold_data", pipe_out_data, {32'h0, 32'hDEAD_BEEF});
      chk("hold_valid", pipe_valid, 1'b1);
`ifdef PIPE_EX_MEM_PERF_EN
      chk("hold_perf", perf_hold_cnt, 32'd3);
`endif

      stall_en = 6'b001111; cnt_in = 2'd1; hilo_temp_in = 64'h5A;
      cyc(1);
      chk("pre_flush_cnt", cnt_out, 2'd1);
      stall_en = 6'b011111; flush = 1'b1;
      cyc(1);
      chk("flush_feedback", {hilo_temp_out, cnt_out}, 66'h0);
      chk("flush_valid", pipe_valid, 1'b0);
`ifdef PIPE_EX_MEM_PERF_EN
      chk("flush_perf", {perf_bubble_cnt, perf_hold_cnt}, {32'd2, 32'd3});
`endif
      flush = 1'b0;

      for (int i = 0; i < 12; i++) begin
         stall_en = stall_tab[i];
         flush = (i == 9);
         out_addr = 10'(i * 37 + 5);
         out_en = 2'(i);
         out_data = {32'(i * 32'h0101_0101), 32'(32'hF000_0000 + i)};
         hilo_wr_en = i[0];
         hilo_wr_hi = 32'(i * 3);
         hilo_wr_lo = 32'(i * 5);
         hilo_temp_in = 64'(64'h1_0000_0000 + i);
         cnt_in = 2'(i + 1);
         cyc(1);
      end
      flush = 1'b0;

      stall_en = 6'b001111; cnt_in = 2'd1;
      cyc(1);
      reset = 1'b0; flush = 1'b1; stall_en = 6'b011111;
      cyc(1);
      chk("rstflush_all",
          {pipe_out_addr, pipe_out_en, pipe_out_data, pipe_valid, hilo_temp_out, cnt_out},
          '0);
`ifdef PIPE_EX_MEM_PERF_EN
      chk("rstflush_perf", {perf_bubble_cnt, perf_hold_cnt}, 64'h0);
`endif
      reset = 1'b1; flush = 1'b0; stall_en = '0;
      cyc(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
